// File: rtl/ufm_writer.sv
// SPI initiator programming one 16-bit UFM word per request: WREN, WRITE, then RDSR polling.
// Optional read-back compare of the programmed word when UFM_WRITER_VERIFY_EN is defined.
module ufm_writer #(
    parameter int SCK_HALF = 1,
    parameter int NCS_GAP  = 4,
    parameter int POLL_MAX = 4095
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [8:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_ncs,
    output logic        spi_sck,
    output logic        spi_si,
    input  logic        spi_so
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int GW = (NCS_GAP > 1) ? $clog2(NCS_GAP) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(NCS_GAP - 1);
    localparam logic [11:0]   POLL_LIM  = 12'(POLL_MAX);

`ifdef UFM_WRITER_VERIFY_EN
    localparam int RXW = 16;
`else
    localparam int RXW = 1;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP1,
        S_WRITE,
        S_GAP2,
        S_POLL,
`ifdef UFM_WRITER_VERIFY_EN
        S_GAP3,
        S_VERIFY,
`endif
        S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic            busy_nxt, done_nxt, err_nxt;
    logic            ncs_nxt, sck_nxt, si_nxt;
    logic [HW-1:0]   half_cnt, half_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic [5:0]      bit_cnt, bit_nxt;
    logic            stat_phase, stat_nxt;
    logic [11:0]     poll_cnt, poll_nxt, poll_inc;
    logic [39:0]     shreg, sh_nxt;
    logic [RXW-1:0]  rx, rx_nxt;
    logic [8:0]      addr_q, addr_nxt;
    logic [15:0]     data_q, data_nxt;
    logic            half_done;
    logic            load, frame_end;
    logic [39:0]     load_word;
    logic [5:0]      load_bits;

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = err;
        ncs_nxt   = spi_ncs;
        sck_nxt   = spi_sck;
        si_nxt    = spi_si;
        half_nxt  = half_cnt;
        gap_nxt   = gap_cnt;
        bit_nxt   = bit_cnt;
        stat_nxt  = stat_phase;
        poll_nxt  = poll_cnt;
        sh_nxt    = shreg;
        rx_nxt    = rx;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        load      = 1'b0;
        load_word = '0;
        load_bits = '0;
        frame_end = 1'b0;
        half_done = (half_cnt == HALF_LAST);
        poll_inc  = (poll_cnt == 12'hFFF) ? poll_cnt : poll_cnt + 12'd1;

        case (state)
            S_IDLE: begin
                if (wr_req) begin
                    addr_nxt  = wr_addr;
                    data_nxt  = wr_data;
                    busy_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                    poll_nxt  = '0;
                    load      = 1'b1;
                    load_word = {8'h06, 32'h0};
                    load_bits = 6'd8;
                    state_nxt = S_WREN;
                end
            end
            S_GAP1: begin
                if (gap_cnt == GAP_LAST) begin
                    load      = 1'b1;
                    load_word = {8'h02, 7'b0, addr_q, data_q};
                    load_bits = 6'd40;
                    state_nxt = S_WRITE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            S_GAP2: begin
                if (gap_cnt == GAP_LAST) begin
                    load      = 1'b1;
                    load_word = {8'h05, 32'h0};
                    load_bits = 6'd8;
                    state_nxt = S_POLL;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
`ifdef UFM_WRITER_VERIFY_EN
            S_GAP3: begin
                if (gap_cnt == GAP_LAST) begin
                    load      = 1'b1;
                    load_word = {8'h03, 7'b0, addr_q, 16'h0};
                    load_bits = 6'd40;
                    state_nxt = S_VERIFY;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
`endif
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                // Shared bit engine for every ncs-low command frame.
                if (!half_done) begin
                    half_nxt = half_cnt + 1'b1;
                end else begin
                    half_nxt = '0;
                    if (spi_sck) begin
                        sck_nxt = 1'b0;
                        sh_nxt  = {shreg[38:0], 1'b0};
                        si_nxt  = shreg[38];
                        // Status bytes are chained without releasing ncs.
                        if (state == S_POLL && bit_cnt == 6'd0) begin
                            if (!stat_phase) begin
                                stat_nxt = 1'b1;
                                bit_nxt  = 6'd8;
                            end else begin
                                poll_nxt = poll_inc;
                                if (rx[0]) begin
                                    if (poll_inc >= POLL_LIM) begin
                                        err_nxt = 1'b1;
                                    end else begin
                                        bit_nxt = 6'd8;
                                    end
                                end
                            end
                        end
                    end else if (bit_cnt != 6'd0) begin
                        sck_nxt = 1'b1;
`ifdef UFM_WRITER_VERIFY_EN
                        rx_nxt  = {rx[14:0], spi_so};
`else
                        rx_nxt  = spi_so;
`endif
                        bit_nxt = bit_cnt - 6'd1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
        endcase

        if (load) begin
            ncs_nxt  = 1'b0;
            sck_nxt  = 1'b0;
            sh_nxt   = load_word;
            si_nxt   = load_word[39];
            bit_nxt  = load_bits;
            half_nxt = '0;
            stat_nxt = 1'b0;
        end

        if (frame_end) begin
            ncs_nxt = 1'b1;
            si_nxt  = 1'b0;
            gap_nxt = '0;
            case (state)
                S_WREN:   state_nxt = S_GAP1;
                S_WRITE:  state_nxt = S_GAP2;
`ifdef UFM_WRITER_VERIFY_EN
                S_POLL:   state_nxt = err ? S_FIN : S_GAP3;
                S_VERIFY: begin
                    state_nxt = S_FIN;
                    if (rx != data_q) err_nxt = 1'b1;
                end
`endif
                default:  state_nxt = S_FIN;
            endcase
            if (state_nxt == S_FIN) begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            spi_ncs    <= 1'b1;
            spi_sck    <= 1'b0;
            spi_si     <= 1'b0;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            stat_phase <= 1'b0;
            poll_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            spi_ncs    <= ncs_nxt;
            spi_sck    <= sck_nxt;
            spi_si     <= si_nxt;
            half_cnt   <= half_nxt;
            gap_cnt    <= gap_nxt;
            bit_cnt    <= bit_nxt;
            stat_phase <= stat_nxt;
            poll_cnt   <= poll_nxt;
        end
    end

    always_ff @(posedge clock) begin
        shreg  <= sh_nxt;
        rx     <= rx_nxt;
        addr_q <= addr_nxt;
        data_q <= data_nxt;
    end

endmodule

// File: tb/tb_ufm_writer.sv
// Directed bench for ufm_writer with a behavioural UFM SPI target model.
module tb_ufm_writer;

    localparam int SCK_HALF = 1;
    localparam int NCS_GAP  = 4;
    localparam int POLL_MAX = 8;
`ifdef UFM_WRITER_VERIFY_EN
    localparam int LAT_MIN = 220;
    localparam int LAT_MAX = 225;
`else
    localparam int LAT_MIN = 136;
    localparam int LAT_MAX = 140;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        busy, done, err, spi_ncs, spi_sck, spi_si;
    logic        spi_so = 1'b0;

    ufm_writer #(
        .SCK_HALF (SCK_HALF),
        .NCS_GAP  (NCS_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .spi_ncs (spi_ncs),
        .spi_sck (spi_sck),
        .spi_si  (spi_si),
        .spi_so  (spi_so)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // UFM target model: logs MOSI bytes per ncs window and answers RDSR/READ.
    int          wip_polls = 0;
    logic [15:0] rb_data = 16'hBEEF;
    logic [7:0]  bytes_q[$];
    int          wins_q[$];
    logic [7:0]  cmd_q[$];
    int          rises = 0;
    int          win_bytes = 0;
    logic [7:0]  sh_in = '0;
    logic [7:0]  cmd = '0;
    int          done_cnt = 0;
    int          sck_bad = 0;

    function automatic logic so_bit(input int idx, input logic [7:0] c);
        int k;
        if (idx < 8) return 1'b0;
        if (c == 8'h05) begin
            k = idx - 8;
            return ((k % 8) == 7) && ((k / 8) < wip_polls);
        end
        if (c == 8'h03 && idx >= 24 && idx < 40) return rb_data[15 - (idx - 24)];
        return 1'b0;
    endfunction

    always @(posedge spi_sck or posedge spi_ncs) begin
        if (spi_ncs === 1'b1) begin
            wins_q.push_back(win_bytes);
            cmd_q.push_back(cmd);
            rises     = 0;
            win_bytes = 0;
            cmd       = 8'h00;
        end else begin
            sh_in = {sh_in[6:0], spi_si};
            rises++;
            if (rises % 8 == 0) begin
                bytes_q.push_back(sh_in);
                win_bytes++;
                if (rises == 8) cmd = sh_in;
            end
        end
    end

    always @(negedge spi_sck or negedge spi_ncs)
        spi_so = (spi_ncs === 1'b0) ? so_bit(rises, cmd) : 1'b0;

    always @(posedge clock) if (done === 1'b1) done_cnt++;
    always @(negedge clock) if (spi_ncs === 1'b1 && spi_sck === 1'b1) sck_bad++;

    logic [7:0] exp_b[$];
    int         exp_w[$];

    task automatic start_write(input logic [8:0] a, input logic [15:0] d);
        @(negedge clock);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        @(negedge clock);
        wr_req  = 1'b0;
    endtask

    task automatic wait_done(output int l, output logic e);
        bit seen;
        seen = 1'b0;
        l = 0;
        e = 1'bx;
        while (!seen && l < 400) begin
            @(posedge clock);
            #1;
            l++;
            if (done === 1'b1) begin
                seen = 1'b1;
                e = err;
            end
        end
        if (!seen) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_write(input string tag, input logic [8:0] a, input logic [15:0] d,
                             output int l, output logic e);
        start_write(a, d);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        wait_done(l, e);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_log(input string tag, input int b0, input int w0);
        check({tag, "_nbytes"}, 32'(bytes_q.size() - b0), 32'(exp_b.size()));
        check({tag, "_nwins"}, 32'(wins_q.size() - w0), 32'(exp_w.size()));
        for (int i = 0; i < exp_b.size() && b0 + i < bytes_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(bytes_q[b0 + i]), 32'(exp_b[i]));
        for (int i = 0; i < exp_w.size() && w0 + i < wins_q.size(); i++)
            check($sformatf("%s_win%0d", tag, i), 32'(wins_q[w0 + i]), 32'(exp_w[i]));
    endtask

    int   lat, lat2, lat3, b0, w0, d0, wren;
    logic e;

    initial begin
        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_ncs",  32'(spi_ncs), 32'd1);
        check("rst_sck",  32'(spi_sck), 32'd0);
        check("rst_si",   32'(spi_si),  32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Test 1: reset in the middle of WRITE
        d0 = done_cnt;
        start_write(9'h0A5, 16'hBEEF);
        repeat (40) @(posedge clock);
        #2;
        check("t1_ncs_pre", 32'(spi_ncs), 32'd0);
        check("t1_sck_pre", 32'(spi_sck), 32'd1);
        reset = 1'b1;
        #1;
        check("t1_ncs_rst",  32'(spi_ncs), 32'd1);
        check("t1_sck_rst",  32'(spi_sck), 32'd0);
        check("t1_busy_rst", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        check("t1_no_done", 32'(done_cnt - d0), 32'd0);

        // Test 2: basic write, WIP clear on first poll
        wip_polls = 0;
        rb_data   = 16'hBEEF;
        b0 = bytes_q.size();
        w0 = wins_q.size();
        run_write("t2", 9'h0A5, 16'hBEEF, lat2, e);
        check("t2_err", 32'(e), 32'd0);
        check("t2_lat_in_range", 32'(lat2 >= LAT_MIN && lat2 <= LAT_MAX), 32'd1);
        exp_b = '{8'h06, 8'h02, 8'h00, 8'hA5, 8'hBE, 8'hEF, 8'h05, 8'h00};
        exp_w = '{1, 5, 2};
`ifdef UFM_WRITER_VERIFY_EN
        exp_b.push_back(8'h03); exp_b.push_back(8'h00); exp_b.push_back(8'hA5);
        exp_b.push_back(8'h00); exp_b.push_back(8'h00);
        exp_w.push_back(5);
`endif
        check_log("t2", b0, w0);
        repeat (3) @(negedge clock);

        // Test 3: WIP held for 3 polls
        wip_polls = 3;
        w0 = wins_q.size();
        run_write("t3", 9'h0A5, 16'hBEEF, lat3, e);
        check("t3_err", 32'(e), 32'd0);
        check("t3_poll_bytes", 32'(wins_q[w0 + 2]), 32'd5);
        check("t3_extra_lat", 32'(lat3 - lat2), 32'd48);
        repeat (3) @(negedge clock);

        // Test 4: WIP stuck, poll limit reached
        wip_polls = 100;
        w0 = wins_q.size();
        run_write("t4", 9'h011, 16'h1234, lat, e);
        check("t4_err", 32'(e), 32'd1);
        check("t4_nwins", 32'(wins_q.size() - w0), 32'd3);
        if (wins_q.size() >= w0 + 3) check("t4_poll_bytes", 32'(wins_q[w0 + 2]), 32'd9);
        check("t4_ncs_after", 32'(spi_ncs), 32'd1);
        repeat (3) @(negedge clock);

        // Test 5: second request while busy is dropped
        wip_polls = 0;
        d0 = done_cnt;
        b0 = bytes_q.size();
        w0 = wins_q.size();
        start_write(9'h0A5, 16'hBEEF);
        repeat (8) @(negedge clock);
        wr_addr = 9'h13C;
        wr_data = 16'h1234;
        wr_req  = 1'b1;
        @(negedge clock);
        wr_req  = 1'b0;
        wait_done(lat, e);
        repeat (200) @(negedge clock);
        check("t5_one_done", 32'(done_cnt - d0), 32'd1);
        wren = 0;
        for (int i = w0; i < cmd_q.size(); i++) if (cmd_q[i] == 8'h06) wren++;
        check("t5_one_wren", 32'(wren), 32'd1);
        if (bytes_q.size() >= b0 + 5) begin
            check("t5_addr_hi", 32'(bytes_q[b0 + 2]), 32'h00);
            check("t5_addr_lo", 32'(bytes_q[b0 + 3]), 32'hA5);
            check("t5_data_hi", 32'(bytes_q[b0 + 4]), 32'hBE);
        end else begin
            check("t5_write_bytes", 32'(bytes_q.size() - b0), 32'd8);
        end

`ifdef UFM_WRITER_VERIFY_EN
        // Test 6: read-back compare
        rb_data = 16'hBEEE;
        b0 = bytes_q.size();
        w0 = wins_q.size();
        run_write("t6a", 9'h0A5, 16'hBEEF, lat, e);
        check("t6a_err", 32'(e), 32'd1);
        exp_b = '{8'h06, 8'h02, 8'h00, 8'hA5, 8'hBE, 8'hEF, 8'h05, 8'h00,
                  8'h03, 8'h00, 8'hA5, 8'h00, 8'h00};
        exp_w = '{1, 5, 2, 5};
        check_log("t6a", b0, w0);
        repeat (3) @(negedge clock);
        rb_data = 16'hBEEF;
        run_write("t6b", 9'h0A5, 16'hBEEF, lat, e);
        check("t6b_err", 32'(e), 32'd0);
`endif

        check("sck_high_with_ncs_high", 32'(sck_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
